// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: datapath width,
// controller state type and funct3 operation encodings.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // rs1 is two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is two's complement for MULH, DIV and REM.
    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_if;
    import muldiv_pkg::*;

    logic            startE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMD;
    logic            DoneMD;
    logic [XLEN-1:0] ResultMD;

    modport master (
        output startE, funct3E, SrcAE, SrcBE, FlushE,
        input  StallMD, DoneMD, ResultMD
    );

    modport slave (
        input  startE, funct3E, SrcAE, SrcBE, FlushE,
        output StallMD, DoneMD, ResultMD
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 64-bit accumulator.
//   Multiply: acc = {partial product, remaining multiplier bits}; add the
//             multiplicand to the upper half when the current multiplier bit
//             is set, then shift the 65-bit result right by one.
//   Divide:   acc = {partial remainder, remaining dividend bits}; shift left
//             by one, subtract the divisor when it fits (restoring), and shift
//             the quotient bit in at the bottom.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic            fits;
    logic [XLEN-1:0] sub;

    // Both candidate updates are formed; is_div picks which one is used.
    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // The shifted remainder is 33 bits wide; when it is >= divisor the
        // difference is below the divisor and so fits in 32 bits.
        fits = acc[2*XLEN-1:XLEN-1] >= {1'b0, operand};
        sub  = acc[2*XLEN-2:XLEN-1] - operand;
        if (!is_div) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else if (fits) begin
            acc_next = {sub, acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide controller. Iterative radix-2 multiply and restoring
// divide on operand magnitudes, with sign correction applied in DONE.
// Divide-by-zero and signed overflow finish the cycle after start.
// Build option: define RV_MUL_FAST_EN to compute all MUL* ops with a single
// 33x33 signed multiply (IDLE -> DONE directly); divide is unaffected.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    md_state_t         state, state_d;
    logic [4:0]        cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_step;
    logic              neg_q, neg_r;

    logic              start, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
`ifdef RV_MUL_FAST_EN
    logic signed [XLEN:0]     a_ext, b_ext;
    logic signed [2*XLEN-1:0] prod_fast;
`endif

    function automatic logic [2*XLEN-1:0] cond_neg_dw(input logic [2*XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg_w(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    muldiv_step u_step (
        .is_div   (op[2]),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_step)
    );

    // Condition the operands of the instruction being accepted this cycle.
    always_comb begin
        start    = (state == IDLE) && bus.startE && !bus.FlushE;
        a_neg    = signed_a(bus.funct3E) && bus.SrcAE[XLEN-1];
        b_neg    = signed_b(bus.funct3E) && bus.SrcBE[XLEN-1];
        a_mag    = a_neg ? -bus.SrcAE : bus.SrcAE;
        b_mag    = b_neg ? -bus.SrcBE : bus.SrcBE;
        div_zero = (bus.SrcBE == '0);
        div_ovf  = bus.funct3E[2] && signed_b(bus.funct3E) &&
                   (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcBE == '1);
`ifdef RV_MUL_FAST_EN
        // 33-bit extension lets MULHSU/MULHU share one signed multiplier;
        // the low 64 bits of the widened product are the exact result.
        a_ext     = {signed_a(bus.funct3E) & bus.SrcAE[XLEN-1], bus.SrcAE};
        b_ext     = {signed_b(bus.funct3E) & bus.SrcBE[XLEN-1], bus.SrcBE};
        prod_fast = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bus.funct3E[2]) begin
                        state_d = (div_zero || div_ovf) ? DONE : DIV;
                    end else begin
`ifdef RV_MUL_FAST_EN
                        state_d = DONE;
`else
                        state_d = MUL;
`endif
                    end
                end
            end
            MUL, DIV: begin
                if (bus.FlushE) begin
                    state_d = IDLE;
                end else if (cnt == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on start, one iteration per MUL/DIV cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op    <= '0;
            cnt   <= '0;
            opnd  <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            op  <= bus.funct3E;
            cnt <= '0;
            if (!bus.funct3E[2]) begin
`ifdef RV_MUL_FAST_EN
                acc   <= prod_fast;
                opnd  <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
`else
                acc   <= {{XLEN{1'b0}}, b_mag};
                opnd  <= a_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
`endif
            end else if (div_zero) begin
                // Remainder is the raw dividend, so no sign correction.
                acc   <= {bus.SrcAE, {XLEN{1'b1}}};
                opnd  <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (div_ovf) begin
                acc   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                opnd  <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                acc   <= {{XLEN{1'b0}}, a_mag};
                opnd  <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end
        end else if (((state == MUL) || (state == DIV)) && !bus.FlushE) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
        end
    end

    // Outputs: stall while accepting or iterating, sign-corrected result in DONE.
    always_comb begin
        prod         = cond_neg_dw(acc, neg_q);
        quot         = cond_neg_w(acc[XLEN-1:0], neg_q);
        rem          = cond_neg_w(acc[2*XLEN-1:XLEN], neg_r);
        bus.StallMD  = start || (state == MUL) || (state == DIV);
        bus.DoneMD   = (state == DONE);
        bus.ResultMD = '0;
        if (state == DONE) begin
            case (op)
                F3_MUL:                       bus.ResultMD = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: bus.ResultMD = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              bus.ResultMD = quot;
                default:                      bus.ResultMD = rem;
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: startE  input  1  RV32M op valid in Execute.
REQ-004 SHALL have port: funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port: SrcAE  input  32  rs1 operand (dividend / multiplicand).
REQ-006 SHALL have port: SrcBE  input  32  rs2 operand (divisor / multiplier).
REQ-007 SHALL have port: FlushE  input  1  abort current op.
REQ-008 SHALL have port: StallMD  output  1  stall Fetch/Decode/Execute.
REQ-009 SHALL have port: DoneMD  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port: ResultMD  output  32  result, valid when DoneMD=1.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-012 SHALL, in IDLE with startE=1 and FlushE=0, latch operands and funct3E, clear the 5-bit step counter, and go to MUL (funct3E[2]=0) or DIV (funct3E[2]=1).
REQ-013 SHALL drive StallMD combinationally high in IDLE when startE=1 and FlushE=0, and in every MUL/DIV cycle; low in IDLE otherwise and in DONE.
REQ-014 SHALL perform one radix-2 step per cycle in MUL/DIV: shift-add for MUL, restoring shift-subtract for DIV, on operand magnitudes.
REQ-015 SHALL go to DONE after step 31 (32 cycles in MUL/DIV); DONE lasts one cycle, then IDLE.
REQ-016 SHALL give a latency of 33 stall cycles for iterative ops; DoneMD is high in cycle 34.
REQ-017 SHALL treat operands by signedness: MULH/DIV/REM both signed; MULHSU A signed, B unsigned; others unsigned.
REQ-018 SHALL apply sign correction in DONE: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-019 SHALL select the result as follows: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-020 SHALL, for divisor 0, skip to DONE the cycle after start: quotient 0xFFFFFFFF, remainder = SrcAE.
REQ-021 SHALL, for signed 0x80000000 / 0xFFFFFFFF, skip to DONE the cycle after start: quotient 0x80000000, remainder 0.
REQ-022 SHALL, with FlushE=1 in MUL or DIV, go to IDLE at the next edge, with no DoneMD and StallMD low from that edge.
REQ-023 SHALL ignore startE in MUL, DIV and DONE; startE in DONE is the completing instruction.
REQ-024 SHALL hold DoneMD=0 and ResultMD=0 in all states except DONE.

Reset
REQ-025 SHALL, on reset=0 at a rising edge, including mid-operation, enter IDLE, clear the counter and operand/accumulator registers, and drive StallMD=0, DoneMD=0, ResultMD=0.
REQ-026 SHALL give reset priority over startE and FlushE.

Configuration
REQ-027 SHALL support macro RV_MUL_FAST_EN.
REQ-028 SHALL, with RV_MUL_FAST_EN defined, compute MUL* in a single-cycle 33x33 signed multiply: IDLE goes directly to DONE, giving 1 stall cycle with DoneMD in cycle 2; MUL state unused.
REQ-029 SHALL, without RV_MUL_FAST_EN, use iterative MUL per REQ-014..016; DIV behaviour is identical in both builds.

Structure
REQ-030 SHALL place in shared package muldiv_pkg: the XLEN=32 constant, the state enum type, and named funct3 encodings.
REQ-031 SHALL use one sub-module, muldiv_step, implementing the combinational single-iteration add/subtract-and-shift on the 64-bit accumulator; the FSM, counter and sign correction stay in muldiv_ctrl.

Verification
REQ-032 SHALL cover: DIVU 100/7 -> StallMD high 33 cycles, DoneMD cycle 34, ResultMD=14; REMU gives 2.
REQ-033 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 5/0 -> 0xFFFFFFFF after 1 stall cycle.
REQ-034 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; early-out latency.
REQ-035 SHALL cover: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 1; latency per build (33 or 1 stall cycles).
REQ-036 SHALL cover: FlushE at step 10 of DIV -> IDLE next edge, no DoneMD; a new DIVU 9/3 started next cycle returns 3.
REQ-037 SHALL cover: reset=0 at step 20 of MUL -> all outputs 0 next edge; startE held high through DONE does not restart.
